mem_access: RTL
===============

Name: mem_access

Overview:
- MEM-stage load/store engine; the consumer end of the EX/MEM pipeline register's memory fields (aluop, mem_addr, reg2).
- Decodes the memory op, drives a req/ack data bus with byte lanes, and aligns and extends load data.
- Holds the pipeline via stallreq while the access is in flight, then feeds the MEM/WB register.
- Non-memory ops pass straight through in the same cycle.

Parameters:
- DATA_W, 32, data and register width.
- ADDR_W, 32, data address width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst==0 resets).
- mem_wreg_addr  in  5  destination register from EX/MEM.
- mem_wreg_enable  in  1  write-back enable from EX/MEM.
- mem_wdata  in  DATA_W  ALU result from EX/MEM.
- mem_aluop  in  8  operation code (`AluOpBus).
- mem_mem_addr  in  ADDR_W  effective byte address.
- mem_reg2  in  DATA_W  store data.
- mem_stall  in  1  stall[4] from the pipeline controller; MEM stage held.
- stallreq  out  1  request the controller to stall IF..MEM.
- dbus_req  out  1  bus request, held until ack.
- dbus_we  out  1  1 = store.
- dbus_addr  out  ADDR_W  word address; bits[1:0] always 0.
- dbus_sel  out  4  byte enables, little-endian (sel[0] = bits 7:0).
- dbus_wdata  out  DATA_W  store data replicated into lanes.
- dbus_rdata  in  DATA_W  read data, valid with ack.
- dbus_ack  in  1  one-cycle completion strobe.
- wb_wreg_addr  out  5  to MEM/WB.
- wb_wreg_enable  out  1  to MEM/WB.
- wb_wdata  out  DATA_W  to MEM/WB.
- addr_err  out  1  misaligned-access flag, one cycle.

Behaviour:
- Reset (rst==0, async): state IDLE; dbus_req=0, dbus_we=0, dbus_addr=0, dbus_sel=0, dbus_wdata=0, read capture=0.
- While rst==0, all combinational outputs are forced to 0: stallreq, wb_*, addr_err.
- An async reset mid-access drops dbus_req immediately; an ack arriving afterwards is ignored.
- Memory ops are LB, LBU, LH, LHU, LW, SB, SH, SW; every other aluop is a non-memory op.
- Non-memory op: wb_* equals mem_wreg_addr, mem_wreg_enable and mem_wdata combinationally; stallreq=0; no bus activity.
- Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - addr_err=1 and wb_wreg_enable=0 in the same cycle.
  - No bus request; stallreq=0; state stays IDLE.
- FSM IDLE/BUSY/DONE:
  - IDLE with an aligned memory op: stallreq=1 combinationally. At the next edge, register dbus_req=1, dbus_we, dbus_addr={addr[31:2],2'b00}, dbus_sel and dbus_wdata, then go to BUSY.
  - BUSY: stallreq=1; bus outputs held stable. On dbus_ack=1 at an edge: capture dbus_rdata, dbus_req<=0, go to DONE.
  - DONE: stallreq=0; wb_* carry the result. If mem_stall=1, stay in DONE (result held). Otherwise go to IDLE.
  - Back-to-back memory ops re-enter BUSY from IDLE with no lost cycle beyond one IDLE cycle.
- Minimum latency is 3 cycles per access (IDLE, BUSY with ack, DONE); each extra ack-wait cycle adds one.
- Byte enables:
  - SB/LB/LBU: sel = 1<<addr[1:0].
  - SH/LH/LHU: sel = 0011 or 1100 by addr[1].
  - SW/LW: sel = 1111.
- Store data: byte replicated to all 4 lanes, halfword replicated to both halves, word as-is.
- Load result: select the addressed lane from the captured word, then extend to 32 bits.
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: whole word.
  - wb_wdata = load result in DONE.
- Stores in DONE: wb_wreg_enable follows mem_wreg_enable (0 from decode); wb_wdata = mem_wdata.
- dbus_ack outside BUSY is ignored.

Decomposition:
- consts.vh gains EXE_LB..EXE_SW aluop codes, the ByteSelBus width and the state encodings.
- One natural sub-module, load_align: combinational lane select and extend from (aluop, addr[1:0], word) to a 32-bit result.

Test Plan:
- ADD passthrough with wdata=0x1234 and wreg_addr=5 -> same cycle wb_wdata=0x1234, wb_wreg_enable=1, stallreq=0, dbus_req never 1.
- LB at addr=0x103 with rdata=0x80FF_0000 and ack after 2 wait cycles:
  - Bus: dbus_addr=0x100, sel=1000, stallreq high for 4 cycles.
  - DONE: wb_wdata=0xFFFFFF80.
  - Same access as LBU: DONE wb_wdata=0x00000080.
- SH at addr=0x22 with reg2=0xDEAD_BEEF -> dbus_we=1, addr=0x20, sel=1100, wdata=0xBEEFBEEF; DONE reached after ack.
- LW at addr=0x06 -> addr_err=1, wb_wreg_enable=0, stallreq=0, no dbus_req.
- LW in flight, rst pulsed low in BUSY before ack -> dbus_req=0 immediately, state IDLE; a later stray ack produces no DONE.
- LHU at addr=0x2 with rdata=0x8001_0000 and mem_stall=1 held 3 cycles in DONE -> wb_wdata=0x00008001 stable across all 3 cycles; IDLE afterward.

Source files
------------

// File: rtl/mem_access_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_access_pkg                                         |
// | Description : Memory-op codes, byte-select width, MEM FSM states and |
// |               small decode helpers shared by the MEM-stage engine.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package mem_access_pkg;

    localparam int c_SEL_W = 4;

    localparam logic [7:0] c_EXE_NOP = 8'b0000_0000;
    localparam logic [7:0] c_EXE_ADD = 8'b0010_0000;
    localparam logic [7:0] c_EXE_LB  = 8'b1110_0000;
    localparam logic [7:0] c_EXE_LH  = 8'b1110_0001;
    localparam logic [7:0] c_EXE_LW  = 8'b1110_0011;
    localparam logic [7:0] c_EXE_LBU = 8'b1110_0100;
    localparam logic [7:0] c_EXE_LHU = 8'b1110_0101;
    localparam logic [7:0] c_EXE_SB  = 8'b1110_1000;
    localparam logic [7:0] c_EXE_SH  = 8'b1110_1001;
    localparam logic [7:0] c_EXE_SW  = 8'b1110_1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic is_load_op(input logic [7:0] op);
        return (op == c_EXE_LB) || (op == c_EXE_LBU) || (op == c_EXE_LH) ||
               (op == c_EXE_LHU) || (op == c_EXE_LW);
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        return (op == c_EXE_SB) || (op == c_EXE_SH) || (op == c_EXE_SW);
    endfunction

    function automatic logic is_mem_op(input logic [7:0] op);
        return is_load_op(op) || is_store_op(op);
    endfunction

    function automatic logic is_byte_op(input logic [7:0] op);
        return (op == c_EXE_LB) || (op == c_EXE_LBU) || (op == c_EXE_SB);
    endfunction

    function automatic logic is_half_op(input logic [7:0] op);
        return (op == c_EXE_LH) || (op == c_EXE_LHU) || (op == c_EXE_SH);
    endfunction

    function automatic logic is_word_op(input logic [7:0] op);
        return (op == c_EXE_LW) || (op == c_EXE_SW);
    endfunction

    // Little-endian byte enables for the addressed lane(s)
    function automatic logic [c_SEL_W-1:0] byte_sel(input logic [7:0] op, input logic [1:0] a);
        if (is_byte_op(op)) begin
            return 4'b0001 << a;
        end else if (is_half_op(op)) begin
            return a[1] ? 4'b1100 : 4'b0011;
        end
        return 4'b1111;
    endfunction

    // Replicate the store operand so every enabled lane sees the right bytes
    function automatic logic [31:0] store_lanes(input logic [7:0] op, input logic [31:0] v);
        if (is_byte_op(op)) begin
            return {4{v[7:0]}};
        end else if (is_half_op(op)) begin
            return {2{v[15:0]}};
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_load_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_access_load_align                                  |
// | Description : Picks the addressed byte/halfword out of a captured    |
// |               bus word and sign- or zero-extends it to 32 bits.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mem_access_load_align
    import mem_access_pkg::*;
(
    input  logic [7:0]  aluop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select followed by the extension the opcode asks for
    always_comb begin
        w_byte = word[7:0];
        case (addr_lo)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            default: w_byte = word[31:24];
        endcase
        w_half = addr_lo[1] ? word[31:16] : word[15:0];

        result = word;
        case (aluop)
            c_EXE_LB:  result = {{24{w_byte[7]}}, w_byte};
            c_EXE_LBU: result = {24'd0, w_byte};
            c_EXE_LH:  result = {{16{w_half[15]}}, w_half};
            c_EXE_LHU: result = {16'd0, w_half};
            default:   result = word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_access                                             |
// | Description : MEM-stage load/store engine. Issues req/ack bus        |
// |               accesses with byte lanes, stalls the pipeline while    |
// |               in flight and hands aligned load data to MEM/WB.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mem_access
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          mem_wreg_addr,
    input  logic                mem_wreg_enable,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [7:0]          mem_aluop,
    input  logic [ADDR_W-1:0]   mem_mem_addr,
    input  logic [DATA_W-1:0]   mem_reg2,
    input  logic                mem_stall,
    output logic                stallreq,
    output logic                dbus_req,
    output logic                dbus_we,
    output logic [ADDR_W-1:0]   dbus_addr,
    output logic [c_SEL_W-1:0]  dbus_sel,
    output logic [DATA_W-1:0]   dbus_wdata,
    input  logic [DATA_W-1:0]   dbus_rdata,
    input  logic                dbus_ack,
    output logic [4:0]          wb_wreg_addr,
    output logic                wb_wreg_enable,
    output logic [DATA_W-1:0]   wb_wdata,
    output logic                addr_err
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_req;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_SEL_W-1:0]  r_sel;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [DATA_W-1:0]   w_load_result;
    logic                w_is_mem;
    logic                w_misalign;
    logic                w_start;

    assign w_is_mem   = is_mem_op(mem_aluop);
    assign w_misalign = (is_half_op(mem_aluop) && mem_mem_addr[0]) ||
                        (is_word_op(mem_aluop) && (mem_mem_addr[1:0] != 2'b00));
    assign w_start    = (r_state == ST_IDLE) && w_is_mem && !w_misalign;

    assign dbus_req   = r_req;
    assign dbus_we    = r_we;
    assign dbus_addr  = r_addr;
    assign dbus_sel   = r_sel;
    assign dbus_wdata = r_wdata;

    mem_access_load_align u_load_align (
        .aluop   (mem_aluop),
        .addr_lo (mem_mem_addr[1:0]),
        .word    (r_rdata),
        .result  (w_load_result)
    );

    // Access state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bus request launch, hold-until-ack and read-data capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_sel   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else if (w_start) begin
            r_req   <= 1'b1;
            r_we    <= is_store_op(mem_aluop);
            r_addr  <= {mem_mem_addr[ADDR_W-1:2], 2'b00};
            r_sel   <= byte_sel(mem_aluop, mem_mem_addr[1:0]);
            r_wdata <= store_lanes(mem_aluop, mem_reg2);
        end else if ((r_state == ST_BUSY) && dbus_ack) begin
            r_req   <= 1'b0;
            r_rdata <= dbus_rdata;
        end
    end

    // Next state, stall request and MEM/WB outputs
    always_comb begin
        w_state_nxt    = r_state;
        stallreq       = 1'b0;
        addr_err       = 1'b0;
        wb_wreg_addr   = mem_wreg_addr;
        wb_wreg_enable = mem_wreg_enable;
        wb_wdata       = mem_wdata;

        case (r_state)
            ST_IDLE: begin
                if (w_is_mem) begin
                    wb_wreg_enable = 1'b0;
                    if (w_misalign) begin
                        addr_err = 1'b1;
                    end else begin
                        stallreq    = 1'b1;
                        w_state_nxt = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                stallreq       = 1'b1;
                wb_wreg_enable = 1'b0;
                if (dbus_ack) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (is_load_op(mem_aluop)) begin
                    wb_wdata = w_load_result;
                end
                if (!mem_stall) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Keep the downstream stages quiet while reset is asserted
        if (!rst) begin
            stallreq       = 1'b0;
            addr_err       = 1'b0;
            wb_wreg_addr   = '0;
            wb_wreg_enable = 1'b0;
            wb_wdata       = '0;
        end
    end

endmodule
`default_nettype wire
